// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester-side bus of the memory arbiter: level request, write data, ack pulse, read data
interface mem_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) ();
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter and IDLE/ACCESS/RESP sequencer for a single-port 32x16 memory
module mem_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_arbiter_if.slave      p0,
    mem_arbiter_if.slave      p1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              last_grant
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]        state;
    logic              gnt_q;
    logic              p0_ack_q;
    logic              p1_ack_q;
    logic [DATA_W-1:0] p0_rdata_q;
    logic [DATA_W-1:0] p1_rdata_q;

    logic              any_req;
    logic              win;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    // On contention the port that did not win last time goes first.
    always_comb begin
        any_req = p0.req | p1.req;
        win     = (p0.req && p1.req) ? ~last_grant : p1.req;
        if (win) begin
            win_we    = p1.we;
            win_addr  = p1.addr;
            win_wdata = p1.wdata;
        end else begin
            win_we    = p0.we;
            win_addr  = p0.addr;
            win_wdata = p0.wdata;
        end
    end

    // mem_we doubles as the latched write enable: set on grant, cleared after ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt_q      <= 1'b0;
            last_grant <= 1'b1;
            busy       <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            p0_ack_q   <= 1'b0;
            p1_ack_q   <= 1'b0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else begin
            p0_ack_q <= 1'b0;
            p1_ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        mem_addr   <= win_addr;
                        mem_wdata  <= win_wdata;
                        mem_we     <= win_we;
                        gnt_q      <= win;
                        last_grant <= win;
                        busy       <= 1'b1;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_we <= 1'b0;
                    if (gnt_q) begin
                        p1_rdata_q <= mem_rdata;
                        p1_ack_q   <= 1'b1;
                    end else begin
                        p0_rdata_q <= mem_rdata;
                        p0_ack_q   <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    mem_we <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign p0.ack   = p0_ack_q;
    assign p1.ack   = p1_ack_q;
    assign p0.rdata = p0_rdata_q;
    assign p1.rdata = p1_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter with a behavioural 32x16 memory
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic [4:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic        busy;
    logic        last_grant;

    logic        load_en;
    logic [4:0]  load_addr;
    logic [15:0] load_data;
    logic [15:0] mem [32];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int we_cycles = 0;

    typedef struct {
        logic        port;
        logic [15:0] data;
    } exp_t;
    exp_t sb[$];

    mem_arbiter_if #(.ADDR_W(5), .DATA_W(16)) p0_bus ();
    mem_arbiter_if #(.ADDR_W(5), .DATA_W(16)) p1_bus ();

    mem_arbiter #(.ADDR_W(5), .DATA_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .p0         (p0_bus),
        .p1         (p1_bus),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .last_grant (last_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (load_en) mem[load_addr] <= load_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mem_we) we_cycles++;
        if (p0_bus.ack || p1_bus.ack) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            chk("ack_exclusive", 32'(p0_bus.ack & p1_bus.ack), 32'd0);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("ack_port", 32'(p1_bus.ack), 32'(e.port));
                chk("ack_rdata", 32'(e.port ? p1_bus.rdata : p0_bus.rdata), 32'(e.data));
            end
        end
    end

    task automatic wait_ack(input logic port, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(port ? p1_bus.ack : p0_bus.ack) && n < 10);
    endtask

    task automatic load(input logic [4:0] a, input logic [15:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int acks;
        rst_n = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        p0_bus.req = 0; p0_bus.we = 0; p0_bus.addr = '0; p0_bus.wdata = '0;
        p1_bus.req = 0; p1_bus.we = 0; p1_bus.addr = '0; p1_bus.wdata = '0;
        @(negedge clk);
        load(5'd5, 16'hA5A5);
        load(5'd31, 16'hBEEF);
        load(5'd7, 16'h0707);

        // Reset values
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_last_grant", 32'(last_grant), 32'd1);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_acks", 32'({p0_bus.ack, p1_bus.ack}), 32'd0);
        chk("rst_rdata", 32'({p0_bus.rdata, p1_bus.rdata}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // p0 read of address 5
        p0_bus.req = 1; p0_bus.we = 0; p0_bus.addr = 5'd5;
        sb.push_back('{1'b0, 16'hA5A5});
        wait_ack(1'b0, n);
        p0_bus.req = 0;
        chk("p0_read_latency", 32'(n), 32'd2);
        chk("p0_read_addr", 32'(mem_addr), 32'd5);
        chk("p0_read_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("p0_read_idle", 32'(busy), 32'd0);
        chk("p0_read_no_we", 32'(we_cycles), 32'd0);

        // p1 write 0x1234 to 31 returns old contents, then read back
        p1_bus.req = 1; p1_bus.we = 1; p1_bus.addr = 5'd31; p1_bus.wdata = 16'h1234;
        sb.push_back('{1'b1, 16'hBEEF});
        @(negedge clk);
        chk("p1_wr_mem_we", 32'(mem_we), 32'd1);
        chk("p1_wr_addr", 32'(mem_addr), 32'd31);
        chk("p1_wr_wdata", 32'(mem_wdata), 32'h1234);
        wait_ack(1'b1, n);
        p1_bus.req = 0;
        chk("p1_wr_latency", 32'(n), 32'd1);
        @(negedge clk);
        p1_bus.req = 1; p1_bus.we = 0;
        sb.push_back('{1'b1, 16'h1234});
        wait_ack(1'b1, n);
        p1_bus.req = 0;
        chk("p1_rd_latency", 32'(n), 32'd2);
        chk("p1_we_one_cycle", 32'(we_cycles), 32'd1);
        @(negedge clk);

        // Simultaneous requests right after reset: p0 first, p1 three cycles later
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        p0_bus.req = 1; p0_bus.we = 0; p0_bus.addr = 5'd5;
        p1_bus.req = 1; p1_bus.we = 0; p1_bus.addr = 5'd31;
        sb.push_back('{1'b0, 16'hA5A5});
        sb.push_back('{1'b1, 16'h1234});
        wait_ack(1'b0, n);
        p0_bus.req = 0;
        chk("contend_p0_latency", 32'(n), 32'd2);
        chk("contend_grant0", 32'(last_grant), 32'd0);
        wait_ack(1'b1, n);
        p1_bus.req = 0;
        chk("contend_p1_gap", 32'(n), 32'd3);
        chk("contend_grant1", 32'(last_grant), 32'd1);
        @(negedge clk);

        // Continuous contention for 12 cycles: acks alternate p0,p1,p0,p1
        p0_bus.req = 1; p1_bus.req = 1;
        sb.push_back('{1'b0, 16'hA5A5});
        sb.push_back('{1'b1, 16'h1234});
        sb.push_back('{1'b0, 16'hA5A5});
        sb.push_back('{1'b1, 16'h1234});
        acks = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (p0_bus.ack || p1_bus.ack) acks++;
            p0_bus.req = !p0_bus.ack;
            p1_bus.req = !p1_bus.ack;
        end
        p0_bus.req = 0; p1_bus.req = 0;
        chk("alt_ack_count", 32'(acks), 32'd4);
        @(negedge clk);
        chk("alt_idle", 32'(busy), 32'd0);

        // Reset during ACCESS of a p1 write to address 7
        p1_bus.req = 1; p1_bus.we = 1; p1_bus.addr = 5'd7; p1_bus.wdata = 16'hDEAD;
        @(negedge clk);
        chk("abort_we_before", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_we_async", 32'(mem_we), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_outputs", 32'({mem_addr, p0_bus.ack, p1_bus.ack}), 32'd0);
        chk("abort_wdata", 32'(mem_wdata), 32'd0);
        chk("abort_rdata", 32'({p0_bus.rdata, p1_bus.rdata}), 32'd0);
        chk("abort_last_grant", 32'(last_grant), 32'd1);
        p1_bus.req = 0; p1_bus.we = 0;
        @(negedge clk);
        chk("abort_no_ack", 32'(p1_bus.ack), 32'd0);
        chk("abort_mem7", 32'(mem[7]), 32'h0707);
        rst_n = 1'b1;
        @(negedge clk);

        // p0 holds req through RESP: second access acked at N+5
        p0_bus.req = 1; p0_bus.we = 0; p0_bus.addr = 5'd5;
        sb.push_back('{1'b0, 16'hA5A5});
        sb.push_back('{1'b0, 16'hA5A5});
        wait_ack(1'b0, n);
        chk("hold_first_latency", 32'(n), 32'd2);
        chk("hold_p1_rdata_a", 32'(p1_bus.rdata), 32'd0);
        wait_ack(1'b0, n);
        p0_bus.req = 0;
        chk("hold_second_gap", 32'(n), 32'd3);
        chk("hold_p1_rdata_b", 32'(p1_bus.rdata), 32'd0);
        @(negedge clk);
        chk("hold_idle", 32'(busy), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name:
mem_arbiter

Overview:
- Two-port round-robin arbiter and sequencer for the single-port 32x16 data memory.
- The memory has a synchronous write and an asynchronous read.
- Port 0 is the instruction-fetch side; port 1 is the load/store side of the CPU.
- Every access goes through a fixed 3-state sequence:
  - latch the winning request;
  - drive the memory for exactly one cycle;
  - return a one-cycle ack with registered read data.

Parameters:
- ADDR_W, 5, memory address width (32 locations)
- DATA_W, 16, memory data width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- p0_req  in  1  port 0 request; level, held until ack
- p0_we  in  1  port 0 write enable (1 = write, 0 = read)
- p0_addr  in  ADDR_W  port 0 address
- p0_wdata  in  DATA_W  port 0 write data
- p0_ack  out  1  port 0 one-cycle completion pulse
- p0_rdata  out  DATA_W  port 0 read data; valid while p0_ack = 1
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata  as port 0, for port 1
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_we  out  1  memory write enable
- mem_rdata  in  DATA_W  asynchronous memory read data
- busy  out  1  high whenever state != IDLE
- last_grant  out  1  port index of the most recent grant

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is rst_n, asynchronous, active-low.
  - Reset clears all state immediately, independent of clk.
- Reset values:
  - State = IDLE.
  - p0_ack = p1_ack = 0; p0_rdata = p1_rdata = 0.
  - mem_addr = 0, mem_wdata = 0, mem_we = 0.
  - busy = 0, last_grant = 1, so port 0 wins the first contention.
  - All outputs are registered.
- IDLE:
  - If no req is high, stay in IDLE.
  - If exactly one req is high, grant that port.
  - If both are high, grant the port != last_grant.
  - On a grant: register addr, wdata and we of the winner into mem_addr, mem_wdata and an internal we_q; record the winner in gnt_q and last_grant; go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_we = we_q, asserted only in this cycle.
  - The memory writes at the closing edge.
  - mem_rdata is captured into the winner's rdata register at that same edge.
  - A write therefore returns the pre-write contents of the location.
  - Go to RESP.
- RESP (1 cycle):
  - Winner's ack = 1; the other ack = 0.
  - mem_we = 0; rdata held.
  - Go to IDLE.
- Requester rule:
  - A requester sees ack at the rising edge ending RESP and drops req at that edge.
  - req is therefore low in the following IDLE cycle, so no duplicate issue occurs.
  - A req still high in that IDLE is treated as a new request.
- Latency and throughput:
  - req high in IDLE cycle N gives ack high in cycle N+2.
  - Next grant is possible at N+3.
  - Peak throughput is 1 access per 3 cycles.
- Stability rule:
  - Inputs of a non-granted port are ignored.
  - A granted port's inputs are not re-sampled after IDLE; changes after the grant have no effect.
- Fairness:
  - last_grant toggles only when a grant is made.
  - Under continuous contention, grants alternate 0,1,0,1…
  - A lone requester is granted every 3 cycles.
- rdata registers:
  - Update only in ACCESS, for the granted port.
  - The other port's rdata is unchanged.
- Address:
  - Passed unchanged, full 0..31 range, no wrap logic.
- Reset mid-operation:
  - Reset asserted in ACCESS drops mem_we to 0 immediately, aborting the write.
  - No ack is produced.
  - The port must re-request after reset.

Test Plan:
- Reset, then p0 read addr 5 (memory holds 0xA5A5) -> mem_addr = 5 in ACCESS, p0_ack at cycle N+2, p0_rdata = 0xA5A5, mem_we never high.
- p1 write addr 31 data 0x1234, then p1 read addr 31 -> mem_we high exactly 1 cycle with mem_addr = 31; the write's rdata = old value; the readback returns 0x1234.
- p0 and p1 both request in the same cycle after reset -> p0 granted first (last_grant = 0), p1 granted next; p1_ack 3 cycles after p0_ack.
- Both requesters continuously re-requesting for 12 cycles -> acks alternate p0,p1,p0,p1; never two consecutive acks to one port.
- rst_n low during ACCESS of a p1 write to addr 7 -> mem_we falls immediately, no p1_ack, memory at addr 7 unchanged, all outputs 0, busy = 0.
- p0 alone holds req through RESP into IDLE -> a second access is issued and acked at cycle N+5; p1_rdata untouched throughout.
